add_round_key_stream: RTL and testbench

- Streaming, parametrised successor of the combinational AES AddRoundKey.
- Holds a bank of NR+1 round keys, written once per key schedule by the key-expansion logic upstream.
- Accepts the AES state as a valid/ready stream of column beats tagged with a round index, XORs each beat with the matching round-key columns and emits a registered output stream.
- Sits between the cipher round datapath (SubBytes/ShiftRows/MixColumns) and the round-state register.

---
 rtl/add_round_key_stream_pkg.sv | 16 +
 rtl/add_round_key_stream_key_bank.sv | 51 +++++
 rtl/add_round_key_stream.sv | 94 +++++++++
 tb/tb_add_round_key_stream.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_round_key_stream_pkg.sv
// add_round_key_stream_pkg: shared AES constants and column-word type.
// Byte order: row 0 of a column sits in the most significant byte.
package add_round_key_stream_pkg;

    localparam int AES_NB     = 4;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef logic [31:0] aes_col_t;

    function automatic aes_col_t masked_key(aes_col_t k, logic ok);
        return ok ? k : '0;
    endfunction

endpackage

// File: rtl/add_round_key_stream_key_bank.sv
// aes_key_bank: NR+1 round keys of four columns, one write port, RP read ports.
// Reads are combinational from the array, so a same-cycle write is seen next cycle.
module aes_key_bank
    import add_round_key_stream_pkg::*;
#(
    parameter int NR = AES_NR_128,
    parameter int RP = 1,
    parameter int RW = $clog2(NR + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [RW-1:0]             wr_round,
    input  logic [1:0]                wr_col,
    input  aes_col_t                  wr_data,
    input  logic                      clr,
    input  logic [RW-1:0]             rd_round,
    input  logic [RP-1:0][1:0]        rd_col,
    output aes_col_t [RP-1:0]         rd_data,
    output logic [RP-1:0]             rd_loaded
);

    aes_col_t                key_mem [NR+1][AES_NB];
    logic [NR:0][AES_NB-1:0] loaded;
    logic                    wr_ok;
    logic                    rd_ok;

    assign wr_ok = wr_round <= RW'(NR);
    assign rd_ok = rd_round <= RW'(NR);

    always_ff @(posedge clk)
        if (wr_en && wr_ok) key_mem[wr_round][wr_col] <= wr_data;

    // a write in the same cycle as a clear still marks its column loaded
    always_ff @(posedge clk or posedge rst)
        if (rst) loaded <= '0;
        else begin
            if (clr) loaded <= '0;
            if (wr_en && wr_ok) loaded[wr_round][wr_col] <= 1'b1;
        end

    always_comb begin
        rd_data   = '0;
        rd_loaded = '0;
        for (int j = 0; j < RP; j++) begin
            rd_data[j]   = key_mem[rd_round][rd_col[j]];
            rd_loaded[j] = rd_ok && loaded[rd_round][rd_col[j]];
        end
    end

endmodule

// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streams state columns through AddRoundKey with a registered output.
// A block is NB/COLS_PER_BEAT beats; its round index is taken from the first beat.
module add_round_key_stream
    import add_round_key_stream_pkg::*;
#(
    parameter int NB            = AES_NB,
    parameter int COLS_PER_BEAT = 1,
    parameter int NR            = AES_NR_128,
    parameter int RW            = $clog2(NR + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_wr_en,
    input  logic [RW-1:0]              key_wr_round,
    input  logic [1:0]                 key_wr_col,
    input  logic [31:0]                key_wr_data,
    input  logic                       key_clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RW-1:0]              in_round,
    input  logic [32*COLS_PER_BEAT-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [32*COLS_PER_BEAT-1:0] out_data,
    output logic                       out_last,
    output logic [RW-1:0]              out_round,
    output logic                       err
);

    localparam int BEATS = NB / COLS_PER_BEAT;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int DW    = 32 * COLS_PER_BEAT;

    logic [CW-1:0]                    cnt;
    logic [RW-1:0]                    rnd_q;
    logic [RW-1:0]                    rnd;
    logic                             accept;
    logic                             last_beat;
    logic                             bad;
    logic [COLS_PER_BEAT-1:0][1:0]    rd_col;
    aes_col_t [COLS_PER_BEAT-1:0]     key_col;
    logic [COLS_PER_BEAT-1:0]         key_ok;
    logic [DW-1:0]                    xored;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_beat = cnt == CW'(BEATS - 1);
    assign rnd       = cnt == '0 ? in_round : rnd_q;
    assign bad       = ~&key_ok;

    aes_key_bank #(.NR(NR), .RP(COLS_PER_BEAT), .RW(RW)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (key_wr_en),
        .wr_round  (key_wr_round),
        .wr_col    (key_wr_col),
        .wr_data   (key_wr_data),
        .clr       (key_clr),
        .rd_round  (rnd),
        .rd_col    (rd_col),
        .rd_data   (key_col),
        .rd_loaded (key_ok)
    );

    // column j of the beat lives in the j-th most significant word
    always_comb begin
        rd_col = '0;
        xored  = '0;
        for (int j = 0; j < COLS_PER_BEAT; j++) begin
            rd_col[j] = 2'(int'(cnt) * COLS_PER_BEAT + j);
            xored[DW-32*(j+1) +: 32] = in_data[DW-32*(j+1) +: 32] ^ masked_key(key_col[j], key_ok[j]);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt       <= '0;
            rnd_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_round <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            cnt       <= last_beat ? '0 : cnt + 1'b1;
            rnd_q     <= rnd;
            out_valid <= 1'b1;
            out_data  <= xored;
            out_last  <= last_beat;
            out_round <= rnd;
            err       <= err | bad;
        end else if (out_ready) out_valid <= 1'b0;

endmodule

// File: tb/tb_add_round_key_stream.sv
// tb_add_round_key_stream: table vectors, hand corner sequences and a randomized
// scoreboard run against a queue-based model of the AddRoundKey stream.
module tb_add_round_key_stream;

    localparam int NR = 10;

    logic         clk = 0, rst = 1;
    logic         kwe = 0, kclr = 0;
    logic [3:0]   kr = 0;
    logic [1:0]   kc = 0;
    logic [31:0]  kd = 0;
    logic         iv1 = 0, iv4 = 0, ordy = 1;
    logic [3:0]   ir = 0;
    logic [31:0]  id1 = 0;
    logic [127:0] id4 = 0;
    logic         rdy1, ov1, ol1, e1, rdy4, ov4, ol4, e4;
    logic [31:0]  od1;
    logic [127:0] od4;
    logic [3:0]   or1, or4;

    always #5 clk = ~clk;

    add_round_key_stream #(.COLS_PER_BEAT(1), .NR(NR)) dut1 (
        .clk(clk), .rst(rst), .key_wr_en(kwe), .key_wr_round(kr), .key_wr_col(kc),
        .key_wr_data(kd), .key_clr(kclr), .in_valid(iv1), .in_ready(rdy1), .in_round(ir),
        .in_data(id1), .out_valid(ov1), .out_ready(ordy), .out_data(od1), .out_last(ol1),
        .out_round(or1), .err(e1)
    );

    add_round_key_stream #(.COLS_PER_BEAT(4), .NR(NR)) dut4 (
        .clk(clk), .rst(rst), .key_wr_en(kwe), .key_wr_round(kr), .key_wr_col(kc),
        .key_wr_data(kd), .key_clr(kclr), .in_valid(iv4), .in_ready(rdy4), .in_round(ir),
        .in_data(id4), .out_valid(ov4), .out_ready(ordy), .out_data(od4), .out_last(ol4),
        .out_round(or4), .err(e4)
    );

    typedef struct {logic [31:0] d; logic last; logic [3:0] rnd;} beat_t;
    typedef struct {logic [3:0] rnd; logic [31:0] key; logic [31:0] st; logic [31:0] exp;} vec_t;

    beat_t       q[$];
    logic [31:0] mkey [16][4];
    logic        mflag [16][4];
    int          mbeat;
    logic [3:0]  mr;
    logic        merr;
    int          checks, errors;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] r, input int c);
        return (int'(r) <= NR && mflag[r][c]) ? mkey[r][c] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 4; c++) mflag[r][c] = 1'b0;
        q.delete();
        mbeat = 0;
        merr  = 1'b0;
    endtask

    // one clock of stimulus on dut1 plus scoreboard bookkeeping for that clock
    task automatic cyc(input logic v, input logic [31:0] d, input logic [3:0] r, input logic o,
                       input logic we, input logic [3:0] wr, input logic [1:0] wc,
                       input logic [31:0] wd, input logic clr);
        beat_t b;
        logic  rdy;
        @(negedge clk);
        iv1 = v; id1 = d; ir = r; ordy = o; kwe = we; kr = wr; kc = wc; kd = wd; kclr = clr; iv4 = 0;
        #1;
        rdy = q.size() == 0 || o;
        chk("in_ready", rdy1, rdy);
        chk("out_valid", ov1, q.size() != 0);
        chk("err", e1, merr);
        if (q.size() != 0) begin
            chk("out_data", od1, q[0].d);
            chk("out_last", ol1, q[0].last);
            chk("out_round", or1, q[0].rnd);
            if (o) void'(q.pop_front());
        end
        if (v && rdy) begin
            if (mbeat == 0) mr = r;
            b.d    = d ^ mk(mr, mbeat);
            b.last = mbeat == 3;
            b.rnd  = mr;
            if (!(int'(mr) <= NR && mflag[mr][mbeat])) merr = 1'b1;
            mbeat = (mbeat + 1) % 4;
            q.push_back(b);
        end
        if (clr) for (int i = 0; i < 16; i++) for (int c = 0; c < 4; c++) mflag[i][c] = 1'b0;
        if (we && int'(wr) <= NR) begin
            mkey[wr][wc]  = wd;
            mflag[wr][wc] = 1'b1;
        end
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic [3:0] r, input logic o);
        cyc(v, d, r, o, 1'b0, 4'd0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic wr_key(input logic [3:0] r, input logic [1:0] c, input logic [31:0] d);
        cyc(1'b0, 32'h0, 4'd0, 1'b1, 1'b1, r, c, d, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; iv1 = 0; iv4 = 0; kwe = 0; kclr = 0; ordy = 1;
        @(negedge clk);
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_out_data", od1, 32'h0);
        chk("rst_out_last", ol1, 1'b0);
        chk("rst_out_round", or1, 4'h0);
        chk("rst_err", e1, 1'b0);
        chk("rst_in_ready", rdy1, 1'b1);
        chk("rst_out_valid4", ov4, 1'b0);
        chk("rst_out_data4", od4, 128'h0);
        model_reset();
        rst = 0;
    endtask

    vec_t tv[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        mr     = 0;
        model_reset();
        do_reset();

        // FIPS-197 round 0 on the full-block instance
        wr_key(0, 0, 32'h2b7e1516);
        wr_key(0, 1, 32'h28aed2a6);
        wr_key(0, 2, 32'habf71588);
        wr_key(0, 3, 32'h09cf4f3c);
        beat(0, 32'h0, 0, 1);
        chk("fips_in_ready", rdy4, 1'b1);
        iv4 = 1;
        id4 = 128'h3243f6a8_885a308d_313198a2_e0370734;
        beat(0, 32'h0, 0, 1);
        chk("fips_valid", ov4, 1'b1);
        chk("fips_data", od4, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
        chk("fips_last", ol4, 1'b1);
        chk("fips_round", or4, 4'd0);
        chk("fips_err", e4, 1'b0);

        // table vectors; in_round is 5 on beats 1..3 and must be ignored
        tv[0] = '{4'd3,  32'h01010101, 32'hffffffff, 32'hfefefefe};
        tv[1] = '{4'd7,  32'ha5a5a5a5, 32'h0f0f0f0f, 32'haaaaaaaa};
        tv[2] = '{4'd10, 32'hffffffff, 32'h12345678, 32'hedcba987};
        tv[3] = '{4'd0,  32'h00000000, 32'hdeadbeef, 32'hdeadbeef};
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) wr_key(tv[i].rnd, 2'(c), tv[i].key);
            for (int k = 0; k < 5; k++) begin
                beat(k < 4, tv[i].st, k == 0 ? tv[i].rnd : 4'd5, 1);
                if (k > 0) begin
                    chk("tbl_data", od1, tv[i].exp);
                    chk("tbl_last", ol1, k == 4);
                    chk("tbl_round", or1, tv[i].rnd);
                end
            end
        end
        chk("tbl_err", e1, 1'b0);

        // backpressure: out_ready low for 3 cycles after beat 0 of a round-3 block
        beat(1, 32'h11111111, 3, 1);
        for (int k = 0; k < 3; k++) begin
            beat(1, 32'h22222222, 3, 0);
            chk("bp_in_ready", rdy1, 1'b0);
            chk("bp_hold", od1, 32'h10101010);
        end
        beat(1, 32'h22222222, 3, 1);
        beat(1, 32'h33333333, 3, 1);
        chk("bp_beat1", od1, 32'h23232323);
        beat(1, 32'h44444444, 3, 1);
        chk("bp_beat2", od1, 32'h32323232);
        beat(0, 32'h0, 0, 1);
        chk("bp_beat3", od1, 32'h45454545);
        chk("bp_last", ol1, 1'b1);
        beat(0, 32'h0, 0, 1);

        // randomized traffic against the scoreboard with every round loaded
        for (int r = 0; r <= NR; r++) for (int c = 0; c < 4; c++) wr_key(4'(r), 2'(c), $urandom());
        for (int i = 0; i < 400; i++)
            beat($urandom_range(0, 3) != 0, $urandom(), 4'($urandom_range(0, NR)), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 16 && mbeat != 0; i++) beat(1, $urandom(), 0, 1);
        beat(0, 32'h0, 0, 1);
        beat(0, 32'h0, 0, 1);

        // key write colliding with a read of the same column
        wr_key(0, 0, 32'h0);
        cyc(1, 32'hc0ffee00, 0, 1, 1, 0, 0, 32'haaaaaaaa, 0);
        beat(1, $urandom(), 0, 1);
        chk("coll_old", od1, 32'hc0ffee00);
        beat(1, $urandom(), 0, 1);
        beat(1, $urandom(), 0, 1);
        beat(1, 32'h12345678, 0, 1);
        beat(1, $urandom(), 0, 1);
        chk("coll_new", od1, 32'hb89efcd2);
        beat(1, $urandom(), 0, 1);
        beat(1, $urandom(), 0, 1);
        beat(0, 32'h0, 0, 1);

        // unloaded key after clear, then an out-of-range round
        cyc(0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 1);
        beat(1, 32'h5a5a5a5a, 2, 1);
        beat(1, $urandom(), 2, 1);
        chk("unl_data", od1, 32'h5a5a5a5a);
        chk("unl_err", e1, 1'b1);
        beat(1, $urandom(), 2, 1);
        beat(1, $urandom(), 2, 1);
        beat(1, 32'h0badf00d, 4'(NR + 1), 1);
        beat(1, $urandom(), 4'(NR + 1), 1);
        chk("oor_data", od1, 32'h0badf00d);
        beat(1, $urandom(), 4'(NR + 1), 1);
        beat(1, $urandom(), 4'(NR + 1), 1);
        beat(0, 32'h0, 0, 1);
        chk("err_sticky", e1, 1'b1);

        // clear and write together: the write's column stays loaded
        cyc(0, 32'h0, 0, 1, 1, 2, 0, 32'h00000001, 1);
        beat(1, 32'hf0f0f0f0, 2, 1);
        beat(1, $urandom(), 2, 1);
        chk("clr_wr_data", od1, 32'hf0f0f0f1);
        beat(1, $urandom(), 2, 1);
        beat(1, $urandom(), 2, 1);
        beat(0, 32'h0, 0, 1);

        // reset after beat 1 of a block
        for (int c = 0; c < 4; c++) wr_key(1, 2'(c), 32'h0f0f0f0f);
        beat(1, $urandom(), 1, 1);
        beat(1, $urandom(), 1, 1);
        do_reset();
        beat(1, 32'h77777777, 1, 1);
        beat(1, $urandom(), 1, 1);
        chk("rst_flags_data", od1, 32'h77777777);
        chk("rst_flags_err", e1, 1'b1);
        beat(1, $urandom(), 1, 1);
        beat(1, $urandom(), 1, 1);
        beat(0, 32'h0, 0, 1);
        do_reset();
        for (int c = 0; c < 4; c++) wr_key(1, 2'(c), 32'h0f0f0f0f);
        beat(1, 32'h01234567, 1, 1);
        beat(1, $urandom(), 1, 1);
        chk("fresh_data", od1, 32'h0e2c4a68);
        chk("fresh_last", ol1, 1'b0);
        chk("fresh_round", or1, 4'd1);
        beat(1, $urandom(), 1, 1);
        beat(1, $urandom(), 1, 1);
        beat(0, 32'h0, 0, 1);
        beat(0, 32'h0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
